// File: rtl/led_frame_reader_if.sv
// ============================================================================
// Module   : led_frame_reader_if
// Purpose  : Avalon-MM RAM read port plus valid/ready byte stream bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_frame_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata,
    output st_data, st_valid, st_sop, st_eop,
    input  st_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata,
    input  st_data, st_valid, st_sop, st_eop,
    output st_ready
  );
endinterface

`default_nettype wire

// File: rtl/led_frame_reader.sv
// ============================================================================
// Module   : led_frame_reader
// Purpose  : Reads one LED frame from the colour RAM and streams it out bytewise.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_frame_reader #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int NUM_LEDS  = 60
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        i_start,
  output logic             o_busy,
  output logic             o_frame_done,
  led_frame_reader_if.master bus
);

  localparam int                c_num_bytes = 3 * NUM_LEDS;
  localparam int                c_cnt_w     = (c_num_bytes > 1) ? $clog2(c_num_bytes) : 1;
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(c_num_bytes - 1);
  localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_clken;
  logic                r_pend;
  logic                r_pend_sop;
  logic                r_pend_eop;
  logic [DATA_W-1:0]   r_fifo_data [4];
  logic [3:0]          r_fifo_sop;
  logic [3:0]          r_fifo_eop;
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_count;
  logic                w_issue;
  logic                w_room;
  logic                w_valid;
  logic                w_pop;
  logic                w_head_eop;

  // Room counts both stored bytes and the one read still in the RAM pipeline.
  assign w_room     = (r_count + {2'b00, r_pend}) < 3'd4;
  assign w_valid    = (r_count != 3'd0);
  assign w_pop      = w_valid & bus.st_ready;
  assign w_head_eop = r_fifo_eop[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_READ;
      S_READ: begin
        w_issue = w_room;
        if (w_room && (r_cnt == c_last)) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_pop && w_head_eop) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_addr     <= c_base;
      r_clken    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_sop <= 1'b0;
      r_pend_eop <= 1'b0;
      r_fifo_sop <= '0;
      r_fifo_eop <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < 4; i++) r_fifo_data[i] <= '0;
    end else begin
      r_clken <= 1'b1;
      if ((r_state == S_IDLE) && i_start) begin
        r_cnt  <= '0;
        r_addr <= c_base;
      end else if (w_issue) begin
        r_cnt  <= r_cnt + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
      // Frame tags travel alongside the read so they land with their byte.
      r_pend     <= w_issue;
      r_pend_sop <= (r_cnt == '0);
      r_pend_eop <= (r_cnt == c_last);
      if (r_pend) begin
        r_fifo_data[r_wr_ptr] <= bus.mem_readdata;
        r_fifo_sop[r_wr_ptr]  <= r_pend_sop;
        r_fifo_eop[r_wr_ptr]  <= r_pend_eop;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({r_pend, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.mem_address    = r_clken ? r_addr : '0;
  assign bus.mem_chipselect = w_issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_writedata  = '0;
  assign bus.mem_clken      = r_clken;

  assign bus.st_valid = w_valid;
  assign bus.st_data  = r_fifo_data[r_rd_ptr];
  assign bus.st_sop   = r_fifo_sop[r_rd_ptr];
  assign bus.st_eop   = w_head_eop;

  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_led_frame_reader.sv
// ============================================================================
// Module   : tb_led_frame_reader
// Purpose  : Directed, table-driven self-checking bench for led_frame_reader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_frame_reader;

  logic clk = 1'b0;
  logic reset_n;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;

  always #5 clk = ~clk;

  led_frame_reader_if #(.ADDR_W(13), .DATA_W(8)) bus_a ();
  led_frame_reader_if #(.ADDR_W(13), .DATA_W(8)) bus_b ();

  led_frame_reader #(.ADDR_W(13), .DATA_W(8), .BASE_ADDR(0), .NUM_LEDS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(start_a),
    .o_busy(busy_a), .o_frame_done(done_a), .bus(bus_a.master)
  );

  led_frame_reader #(.ADDR_W(13), .DATA_W(8), .BASE_ADDR(8190), .NUM_LEDS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(start_b),
    .o_busy(busy_b), .o_frame_done(done_b), .bus(bus_b.master)
  );

  // RAM models with one-cycle read latency: a holds 0x10+addr, b holds addr^0x5A
  always @(posedge clk)
    if (bus_a.mem_chipselect) bus_a.mem_readdata <= 8'h10 + bus_a.mem_address[7:0];
  always @(posedge clk)
    if (bus_b.mem_chipselect) bus_b.mem_readdata <= bus_b.mem_address[7:0] ^ 8'h5A;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] data; logic sop; logic eop; } byte_t;
  typedef struct { int mode; int first_valid; int done_cyc; int stall_cs; } scen_t;

  byte_t exp_a [12];
  scen_t scen  [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // modes: 0 ready=1, 1 alternating ready, 2 stall 20 cycles after first valid,
  //        3 ready=1 with stray starts in READ and DONE, 4 reset after byte 5
  task automatic run_frame(input int mode, input int first_valid, input int done_cyc,
                           input int stall_cs);
    int cyc, nacc, ncs, fv, dcyc;
    logic       pstall;
    logic [9:0] phead;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0; nacc = 0; ncs = 0; fv = -1; dcyc = -1; pstall = 1'b0; phead = '0;
    while (cyc < 200) begin
      case (mode)
        1:       bus_a.st_ready = (cyc % 2) == 1;
        2:       bus_a.st_ready = (fv >= 0) && (cyc >= fv + 20);
        3: begin bus_a.st_ready = 1'b1; start_a = (cyc == 4) || (cyc == 14); end
        default: bus_a.st_ready = 1'b1;
      endcase
      if (bus_a.mem_chipselect) ncs++;
      if (cyc == 0) check("first_cs", 32'(bus_a.mem_chipselect), 32'd1);
      if (bus_a.st_valid && fv < 0) fv = cyc;
      if (pstall)
        check("hold", 32'({bus_a.st_valid, bus_a.st_sop, bus_a.st_eop, bus_a.st_data}),
              32'({1'b1, phead}));
      if (stall_cs >= 0 && fv >= 0 && cyc == fv + 20) check("stall_cs", 32'(ncs), 32'(stall_cs));
      if (done_a) begin
        dcyc = cyc;
        check("busy_in_done", 32'(busy_a), 32'd1);
        break;
      end
      if (bus_a.st_valid && bus_a.st_ready) begin
        if (nacc < 12)
          check("byte", 32'({bus_a.st_sop, bus_a.st_eop, bus_a.st_data}),
                32'({exp_a[nacc].sop, exp_a[nacc].eop, exp_a[nacc].data}));
        else
          check("extra_byte", 32'(nacc), 32'd11);
        nacc++;
      end
      pstall = bus_a.st_valid && !bus_a.st_ready;
      phead  = {bus_a.st_sop, bus_a.st_eop, bus_a.st_data};
      @(posedge clk); #1;
      cyc++;
      if (mode == 4 && nacc == 6) begin
        reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus_a.st_valid), 32'd0);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_cs",    32'(bus_a.mem_chipselect), 32'd0);
        return;
      end
    end
    check("first_valid", 32'(fv), 32'(first_valid));
    check("done_cyc",    32'(dcyc), 32'(done_cyc));
    check("n_accepted",  32'(nacc), 32'd12);
    check("n_issued",    32'(ncs), 32'd12);
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("idle_busy", 32'({busy_a, done_a}), 32'd0);
      check("idle_cs",   32'(bus_a.mem_chipselect), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [12:0] addr_seen [3];
    logic [9:0]  byte_seen [3];
    int na, nb;

    for (int i = 0; i < 12; i++)
      exp_a[i] = '{data: 8'(8'h10 + i), sop: (i == 0), eop: (i == 11)};
    scen[0] = '{0, 2, 14, -1};
    scen[1] = '{1, 2, 26, -1};
    scen[2] = '{2, 2, 34,  4};
    scen[3] = '{3, 2, 14, -1};
    scen[4] = '{0, 2, 14, -1};

    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    bus_a.st_ready = 1'b1; bus_b.st_ready = 1'b1;
    #12;
    check("reset_outs", 32'({busy_a, done_a, bus_a.st_valid, bus_a.mem_chipselect,
                             bus_a.mem_clken, bus_a.st_sop, bus_a.st_eop}), 32'd0);
    check("reset_data", 32'(bus_a.st_data), 32'd0);
    check("reset_addr", 32'(bus_a.mem_address), 32'd0);
    #10;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("clken_after", 32'(bus_a.mem_clken), 32'd1);
    check("mem_write",   32'({bus_a.mem_write, bus_a.mem_writedata}), 32'd0);
    check("idle_after",  32'({busy_a, done_a, bus_a.st_valid}), 32'd0);

    for (int s = 0; s < 5; s++)
      run_frame(scen[s].mode, scen[s].first_valid, scen[s].done_cyc, scen[s].stall_cs);

    // abort mid-frame, then a clean frame must start again at the base address
    run_frame(4, 0, 0, -1);
    #20;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_idle", 32'({busy_a, bus_a.st_valid}), 32'd0);
    run_frame(0, 2, 14, -1);

    // address wrap on the second instance
    for (int i = 0; i < 3; i++) begin addr_seen[i] = '1; byte_seen[i] = '1; end
    na = 0; nb = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus_b.mem_chipselect) begin
        if (na < 3) addr_seen[na] = bus_b.mem_address;
        na++;
      end
      if (bus_b.st_valid) begin
        if (nb < 3) byte_seen[nb] = {bus_b.st_sop, bus_b.st_eop, bus_b.st_data};
        nb++;
      end
      @(posedge clk); #1;
    end
    check("wrap_n_issue", 32'(na), 32'd3);
    check("wrap_addr0", 32'(addr_seen[0]), 32'd8190);
    check("wrap_addr1", 32'(addr_seen[1]), 32'd8191);
    check("wrap_addr2", 32'(addr_seen[2]), 32'd0);
    check("wrap_n_bytes", 32'(nb), 32'd3);
    check("wrap_byte0", 32'(byte_seen[0]), 32'h2A4);
    check("wrap_byte1", 32'(byte_seen[1]), 32'h0A5);
    check("wrap_byte2", 32'(byte_seen[2]), 32'h15A);
    check("wrap_idle", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
